// File: rtl/uproc_control.sv
// Fetch/decode/execute controller for the 8-bit uProcessor: owns PC, IR and carry.
// Define UPROC_CTRL_BRANCH_EN to implement JC/JNC; otherwise they decode as NOPs.
module uproc_control #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] pc_o,
    input  logic [7:0]      instr_i,
    output logic [2:0]      alu_code_o,
    output logic            ci_o,
    input  logic            co_i,
    output logic [3:0]      reg_sel_o,
    output logic            acc_we_o,
    output logic            reg_we_o,
    output logic            halted_o
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_OPWAIT, S_OPLOAD, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LD, OP_SPECIAL
    } op_t;

    localparam logic [4:0] SUB_JMP  = 5'h01;
    localparam logic [4:0] SUB_JC   = 5'h02;
    localparam logic [4:0] SUB_JNC  = 5'h03;
    localparam logic [4:0] SUB_CLC  = 5'h04;
    localparam logic [4:0] SUB_SEC  = 5'h05;
    localparam logic [4:0] SUB_HALT = 5'h0F;

`ifdef UPROC_CTRL_BRANCH_EN
    localparam logic BRANCH_EN = 1'b1;
`else
    localparam logic BRANCH_EN = 1'b0;
`endif

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic            c_q, c_d;
    logic            acc_we, reg_we;

    op_t        ir_op;
    logic [4:0] ir_sub;
    op_t        in_op;
    logic [4:0] in_sub;
    logic       in_is_jump;
    logic       jump_taken;

    assign ir_op  = op_t'(ir_q[7:5]);
    assign ir_sub = ir_q[4:0];
    assign in_op  = op_t'(instr_i[7:5]);
    assign in_sub = instr_i[4:0];

    // Two-byte instructions are recognised while the opcode byte is on instr_i.
    assign in_is_jump = (in_op == OP_SPECIAL) &&
                        ((in_sub == SUB_JMP) ||
                         (BRANCH_EN && ((in_sub == SUB_JC) || (in_sub == SUB_JNC))));

    always_comb begin
        jump_taken = 1'b1;
        if (ir_sub == SUB_JC)  jump_taken = c_q;
        if (ir_sub == SUB_JNC) jump_taken = ~c_q;
    end

    // NOTE: every combinational output gets a default first, so no path leaves
    // a signal unassigned and no latch can be inferred.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        c_d     = c_q;
        acc_we  = 1'b0;
        reg_we  = 1'b0;

        unique case (state_q)
            S_FETCH: state_d = S_DECODE;

            S_DECODE: begin
                ir_d    = instr_i;
                pc_d    = pc_q + PC_W'(1);
                state_d = in_is_jump ? S_OPWAIT : S_EXEC;
            end

            S_EXEC: begin
                state_d = S_FETCH;
                if (ir_op != OP_SPECIAL) begin
                    acc_we = 1'b1;
                    // Only ADD/SUB produce a carry; every other ALU op clears it.
                    c_d = ((ir_op == OP_ADD) || (ir_op == OP_SUB)) ? co_i : 1'b0;
                end else if (ir_q[4]) begin
                    reg_we = 1'b1;
                end else begin
                    case (ir_sub)
                        SUB_CLC:  c_d = 1'b0;
                        SUB_SEC:  c_d = 1'b1;
                        SUB_HALT: state_d = S_HALT;
                        default:  ;
                    endcase
                end
            end

            S_OPWAIT: state_d = S_OPLOAD;

            S_OPLOAD: begin
                pc_d    = jump_taken ? instr_i : pc_q + PC_W'(1);
                state_d = S_FETCH;
            end

            S_HALT: state_d = S_HALT;

            default: state_d = S_FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            c_q     <= c_d;
        end
    end

    assign pc_o       = pc_q;
    assign alu_code_o = (ir_op == OP_SPECIAL) ? 3'd6 : ir_q[7:5];
    assign ci_o       = ((ir_op == OP_ADD) || (ir_op == OP_SUB)) & ir_q[4] & c_q;
    assign reg_sel_o  = ir_q[3:0];
    assign acc_we_o   = acc_we & ~rst;
    assign reg_we_o   = reg_we & ~rst;
    assign halted_o   = (state_q == S_HALT);

endmodule

// File: tb/tb_uproc_control.sv
// Directed bench for uproc_control with a 1-cycle-latency program ROM model.
// Outputs are sampled on the falling clock edge.
module tb_uproc_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pc_o;
    logic [7:0] instr_i = 8'h00;
    logic [2:0] alu_code_o;
    logic       ci_o;
    logic       co_i = 1'b0;
    logic [3:0] reg_sel_o;
    logic       acc_we_o;
    logic       reg_we_o;
    logic       halted_o;

    logic [7:0] rom [256];

    int checks = 0;
    int errors = 0;

    uproc_control #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_o       (pc_o),
        .instr_i    (instr_i),
        .alu_code_o (alu_code_o),
        .ci_o       (ci_o),
        .co_i       (co_i),
        .reg_sel_o  (reg_sel_o),
        .acc_we_o   (acc_we_o),
        .reg_we_o   (reg_we_o),
        .halted_o   (halted_o)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data for the address seen at an edge appears after it.
    always @(posedge clk) instr_i <= rom[pc_o];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [7:0] pc, input logic acc,
                       input logic rw, input logic halt);
        chk({tag, ".pc"},  32'(pc_o),     32'(pc));
        chk({tag, ".acc"}, 32'(acc_we_o), 32'(acc));
        chk({tag, ".reg"}, 32'(reg_we_o), 32'(rw));
        chk({tag, ".hlt"}, 32'(halted_o), 32'(halt));
        @(negedge clk);
    endtask

    task automatic ex(input string tag, input logic [2:0] code, input logic [3:0] sel,
                      input logic ci);
        chk({tag, ".code"}, 32'(alu_code_o), 32'(code));
        chk({tag, ".sel"},  32'(reg_sel_o),  32'(sel));
        chk({tag, ".ci"},   32'(ci_o),       32'(ci));
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = 8'hE0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ex(tag, 3'd0, 4'd0, 1'b0);
    endtask

    initial begin
        rom_clear();
        @(negedge clk);

        // Straight-line ALU, carry, jump, store and halt
        rom[8'h00] = 8'h03;  // ADD R3
        rom[8'h01] = 8'hE5;  // SEC
        rom[8'h02] = 8'h11;  // ADD+C R1
        rom[8'h03] = 8'h14;  // ADD+C R4
        rom[8'h04] = 8'h42;  // AND R2
        rom[8'h05] = 8'h15;  // ADD+C R5
        rom[8'h06] = 8'hE1;  // JMP
        rom[8'h07] = 8'h40;
        rom[8'h40] = 8'hF7;  // ST R7
        rom[8'h41] = 8'hEF;  // HALT
        do_reset("rstA");
        co_i = 1'b0;
        cyc("add_f", 8'h00, 0, 0, 0);
        cyc("add_d", 8'h00, 0, 0, 0);
        ex("add_e", 3'd0, 4'd3, 1'b0);
        cyc("add_e", 8'h01, 1, 0, 0);
        cyc("add_nf", 8'h01, 0, 0, 0);
        cyc("sec_d", 8'h01, 0, 0, 0);
        cyc("sec_e", 8'h02, 0, 0, 0);
        co_i = 1'b1;
        cyc("adc1_f", 8'h02, 0, 0, 0);
        cyc("adc1_d", 8'h02, 0, 0, 0);
        ex("adc1_e", 3'd0, 4'd1, 1'b1);
        cyc("adc1_e", 8'h03, 1, 0, 0);
        cyc("adc4_f", 8'h03, 0, 0, 0);
        cyc("adc4_d", 8'h03, 0, 0, 0);
        ex("adc4_e", 3'd0, 4'd4, 1'b1);
        cyc("adc4_e", 8'h04, 1, 0, 0);
        cyc("and_f", 8'h04, 0, 0, 0);
        cyc("and_d", 8'h04, 0, 0, 0);
        ex("and_e", 3'd2, 4'd2, 1'b0);
        cyc("and_e", 8'h05, 1, 0, 0);
        co_i = 1'b0;
        cyc("adc5_f", 8'h05, 0, 0, 0);
        cyc("adc5_d", 8'h05, 0, 0, 0);
        ex("adc5_e", 3'd0, 4'd5, 1'b0);
        cyc("adc5_e", 8'h06, 1, 0, 0);
        cyc("jmp_f", 8'h06, 0, 0, 0);
        cyc("jmp_d", 8'h06, 0, 0, 0);
        cyc("jmp_w", 8'h07, 0, 0, 0);
        cyc("jmp_l", 8'h07, 0, 0, 0);
        cyc("st_f", 8'h40, 0, 0, 0);
        cyc("st_d", 8'h40, 0, 0, 0);
        ex("st_e", 3'd6, 4'd7, 1'b0);
        cyc("st_e", 8'h41, 0, 1, 0);
        cyc("hlt_f", 8'h41, 0, 0, 0);
        cyc("hlt_d", 8'h41, 0, 0, 0);
        cyc("hlt_e", 8'h42, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc("halt", 8'h42, 0, 0, 1);

        // Conditional branches with C=0
        rom_clear();
`ifdef UPROC_CTRL_BRANCH_EN
        rom[8'h00] = 8'hE2;  // JC 0x80 (not taken)
        rom[8'h01] = 8'h80;
        rom[8'h02] = 8'hE3;  // JNC 0x80 (taken)
        rom[8'h03] = 8'h80;
        rom[8'h80] = 8'hEF;
        do_reset("rstB");
        cyc("jc_f", 8'h00, 0, 0, 0);
        cyc("jc_d", 8'h00, 0, 0, 0);
        cyc("jc_w", 8'h01, 0, 0, 0);
        cyc("jc_l", 8'h01, 0, 0, 0);
        cyc("jnc_f", 8'h02, 0, 0, 0);
        cyc("jnc_d", 8'h02, 0, 0, 0);
        cyc("jnc_w", 8'h03, 0, 0, 0);
        cyc("jnc_l", 8'h03, 0, 0, 0);
        cyc("br_hf", 8'h80, 0, 0, 0);
        cyc("br_hd", 8'h80, 0, 0, 0);
        cyc("br_he", 8'h81, 0, 0, 0);
        cyc("br_h", 8'h81, 0, 0, 1);
`else
        rom[8'h00] = 8'hE2;  // NOP in this build
        rom[8'h01] = 8'hE3;  // NOP in this build
        rom[8'h02] = 8'hEF;
        do_reset("rstB");
        cyc("jc_f", 8'h00, 0, 0, 0);
        cyc("jc_d", 8'h00, 0, 0, 0);
        cyc("jc_e", 8'h01, 0, 0, 0);
        cyc("jnc_f", 8'h01, 0, 0, 0);
        cyc("jnc_d", 8'h01, 0, 0, 0);
        cyc("jnc_e", 8'h02, 0, 0, 0);
        cyc("br_hf", 8'h02, 0, 0, 0);
        cyc("br_hd", 8'h02, 0, 0, 0);
        cyc("br_he", 8'h03, 0, 0, 0);
        cyc("br_h", 8'h03, 0, 0, 1);
`endif

        // Reset during the operand wait of a JMP at 0xFF, with C set beforehand
        rom_clear();
        rom[8'h00] = 8'hE5;  // SEC
        rom[8'h01] = 8'hE1;  // JMP 0xFF
        rom[8'h02] = 8'hFF;
        rom[8'hFF] = 8'hE1;  // JMP, operand comes from 0x00
        do_reset("rstC");
        cyc("c_sec_f", 8'h00, 0, 0, 0);
        cyc("c_sec_d", 8'h00, 0, 0, 0);
        cyc("c_sec_e", 8'h01, 0, 0, 0);
        cyc("c_j1_f", 8'h01, 0, 0, 0);
        cyc("c_j1_d", 8'h01, 0, 0, 0);
        cyc("c_j1_w", 8'h02, 0, 0, 0);
        cyc("c_j1_l", 8'h02, 0, 0, 0);
        cyc("c_j2_f", 8'hFF, 0, 0, 0);
        cyc("c_j2_d", 8'hFF, 0, 0, 0);
        chk("c_j2_w.wrap", 32'(pc_o), 32'h00);
        rst = 1'b1;
        rom[8'h00] = 8'h11;  // ADD+C R1 exposes the carry after reset
        @(negedge clk);
        chk("c_rst.pc", 32'(pc_o), 32'h00);
        chk("c_rst.acc", 32'(acc_we_o), 32'h0);
        chk("c_rst.reg", 32'(reg_we_o), 32'h0);
        rst = 1'b0;
        cyc("c_adc_f", 8'h00, 0, 0, 0);
        cyc("c_adc_d", 8'h00, 0, 0, 0);
        ex("c_adc_e", 3'd0, 4'd1, 1'b0);
        cyc("c_adc_e", 8'h01, 1, 0, 0);

        // NOP at 0xFF wraps the PC
        rom_clear();
        rom[8'h00] = 8'hE1;  // JMP 0xFF
        rom[8'h01] = 8'hFF;
        do_reset("rstD");
        cyc("d_j_f", 8'h00, 0, 0, 0);
        cyc("d_j_d", 8'h00, 0, 0, 0);
        cyc("d_j_w", 8'h01, 0, 0, 0);
        cyc("d_j_l", 8'h01, 0, 0, 0);
        cyc("d_nop_f", 8'hFF, 0, 0, 0);
        cyc("d_nop_d", 8'hFF, 0, 0, 0);
        cyc("d_nop_e", 8'h00, 0, 0, 0);
        cyc("d_next_f", 8'h00, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
